keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the column lines of a 4x4 matrix keypad and reads its row lines. Produces the raw key_pressed and 4-bit key code that feed the keypad debouncer.
- Sits between the keypad I/O pins and the debouncer. Owns column drive, row synchronisation, key location and the hex code mapping.
- Holds the found column steady while a key is down, so that the debouncer sees a stable code.

Parameters:
- SCAN_DIV, 48000, clk cycles each column is driven before the rows are sampled (1 ms at 48 MHz). Legal values are >= 4.

Ports:
- clk  input  1  system clock (48 MHz HSOSC)
- reset  input  1  synchronous, active-high reset
- row_n  input  4  keypad rows; active-low, externally pulled up, asynchronous to clk
- col_n  output  4  column drive; active-low, exactly one bit low at all times
- key_code  output  4  hex value of the located key; valid while key_pressed = 1
- key_pressed  output  1  high while a key in the held column is detected down
- col_idx  output  2  index of the column currently driven (debug)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - col_n = 4'b1110, col_idx = 0
  - key_code = 4'h0, key_pressed = 0
  - dwell counter = 0, state = SCAN
  - synchroniser flops = 4'b1111
- Synchroniser: row_n passes through a 2-flop synchroniser to give row_s. All decisions use row_s only.
- Dwell counter: counts 0..SCAN_DIV-1 and then wraps. The "sample point" is the cycle where counter == SCAN_DIV-1. Any column change clears the counter to 0.
- State SCAN, at the sample point:
  - If row_s == 4'b1111: advance to the next column (col_idx 3 wraps to 0, col_n rotates its low bit left) and stay in SCAN.
  - If any row_s bit is 0: go to HOLD, keep the column, set key_pressed = 1 and load key_code in the same clock edge.
  - Latency from the sample point to key_pressed = 1 is 1 cycle.
- State HOLD:
  - The column stays frozen and the counter keeps wrapping.
  - At each sample point, if row_s == 4'b1111: clear key_pressed, advance to the next column, go to SCAN.
  - Otherwise stay in HOLD. key_code is re-evaluated from the current row_s, which tracks a row change within the same column.
- Key mapping, row r / column c (row order: c0 c1 c2 c3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D (E = '*', F = '#')
- Multiple rows low in one column: the lowest-index low row wins (unless GHOST_REJECT_EN is defined).
- Keys in other columns are not visible while in HOLD.
- row_s changes between sample points are ignored.
- Reset asserted mid-HOLD or mid-dwell returns to the reset values on the next edge.

Optional Feature:
- GHOST_REJECT_EN defined:
  - In SCAN, a sample showing more than one low row_s bit is treated as no key, and the scan advances.
  - In HOLD, more than one low row keeps key_pressed = 1 with key_code unchanged.
- GHOST_REJECT_EN undefined: the lowest-index-row priority above applies.

Test Plan:
- All tests use SCAN_DIV = 8.
- Reset, then no key: col_n cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, with each value held 8 cycles. key_pressed stays 0 and key_code = 0.
- Key '5' (r1, c1) held, row_n = 4'b1101 while col_n = 4'b1101: key_pressed = 1 one cycle after the sample point in column 1. key_code = 4'h5, col_n frozen at 1101.
- Release '5' (row_n = 4'b1111): key_pressed falls 1 cycle after the next sample point seen after the 2-cycle synchroniser delay. col_n then moves to 1011.
- Key '#' (r3, c2): key_code = 4'hF. Key '*' (r3, c0): key_code = 4'hE. Key 'D' (r3, c3): key_code = 4'hD.
- Rows 0 and 2 low in column 0: key_code = 4'h1 without GHOST_REJECT_EN. With the macro, key_pressed stays 0 and scanning continues.
- Reset asserted while in HOLD on '9': the next cycle shows col_n = 1110, key_pressed = 0, key_code = 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad. The module drives one column low at a time and
// reads the row lines through a 2-flop synchroniser. It reports the first key
// it finds as a raw key_pressed flag plus a hex key code. These outputs feed a
// downstream debouncer. While a key is held, the module freezes the column so
// the debouncer sees a stable code.
//
// Parameters:
//   SCAN_DIV     clk cycles each column is driven before the rows are sampled
//                (legal values >= 4)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   row_n[3:0]   keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   column drive, active-low, exactly one bit low
//   key_code[3:0] hex value of the located key, valid while key_pressed = 1
//   key_pressed  high while a key in the held column is detected down
//   col_idx[1:0] index of the column currently driven (debug)
//
// Handshake: none. key_pressed is a level. key_code is meaningful whenever
// key_pressed is high. After a release, key_code keeps its last value.
//
// Optional feature macro: GHOST_REJECT_EN
//   defined   - a sample with more than one low row is treated as no key
//               while scanning. While holding, it leaves key_code unchanged.
//   undefined - the lowest-index low row wins.
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV = 48000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_pressed,
   output logic [1:0] col_idx
);

   localparam int            CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

`ifdef GHOST_REJECT_EN
   localparam bit GHOST_REJECT = 1'b1;
`else
   localparam bit GHOST_REJECT = 1'b0;
`endif

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    sync1_q, sync2_q;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    col_n_q, col_n_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_pressed_q, key_pressed_d;

   logic [3:0]    row_s;
   logic [3:0]    row_low;
   logic          sample;
   logic          any_low;
   logic          multi_low;
   logic          is_ghost;
   logic [1:0]    low_row;
   logic [3:0]    mapped;
   logic          advance;

   // Hex code for the key at {row, col}.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;  // '*'
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;  // '#'
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   assign row_s     = sync2_q;
   assign row_low   = ~row_s;
   assign sample    = (cnt_q == CNT_MAX);
   assign any_low   = (row_low != 4'h0);
   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_low = ((row_low & (row_low - 4'h1)) != 4'h0);
   assign is_ghost  = GHOST_REJECT && multi_low;
   assign mapped    = key_map(low_row, col_idx_q);

   // Lowest-index low row. The loop runs downward, so row 0 has the last word.
   always_comb begin
      low_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (row_low[r]) low_row = 2'(r);
      end
   end

   // Next-state and output logic.
   // The column only ever moves at a sample point. The counter wraps to 0 on
   // that same edge, so every column change also starts a fresh dwell.
   always_comb begin
      state_d       = state_q;
      cnt_d         = sample ? '0 : cnt_q + CW'(1);
      col_idx_d     = col_idx_q;
      col_n_d       = col_n_q;
      key_code_d    = key_code_q;
      key_pressed_d = key_pressed_q;
      advance       = 1'b0;

      if (sample) begin
         case (state_q)
            SCAN: begin
               if (!any_low || is_ghost) begin
                  advance = 1'b1;
               end else begin
                  state_d       = HOLD;
                  key_pressed_d = 1'b1;
                  key_code_d    = mapped;
               end
            end
            HOLD: begin
               if (!any_low) begin
                  advance       = 1'b1;
                  state_d       = SCAN;
                  key_pressed_d = 1'b0;
               end else if (!is_ghost) begin
                  // Follows a row change within the held column.
                  key_code_d = mapped;
               end
            end
            default: ;
         endcase
      end

      if (advance) begin
         col_idx_d = col_idx_q + 2'd1;
         col_n_d   = {col_n_q[2:0], col_n_q[3]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SCAN;
         cnt_q         <= '0;
         sync1_q       <= 4'hF;
         sync2_q       <= 4'hF;
         col_idx_q     <= 2'd0;
         col_n_q       <= 4'b1110;
         key_code_q    <= 4'h0;
         key_pressed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sync1_q       <= row_n;
         sync2_q       <= sync1_q;
         col_idx_q     <= col_idx_d;
         col_n_q       <= col_n_d;
         key_code_q    <= key_code_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   assign col_n       = col_n_q;
   assign col_idx     = col_idx_q;
   assign key_code    = key_code_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Testbench for keypad_scanner with SCAN_DIV = 8.
//
// A physical keypad model drives row_n from the set of held keys and the
// column the DUT drives. A raw mode can instead force arbitrary row patterns.
//
// The reference model counts edges since reset. Sample points fall every
// SCAN_DIV edges. The model delays rows by two edges and tracks the expected
// column, pressed flag and key code. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int N = 8;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_pressed;
   logic [1:0]  col_idx;

   logic [15:0] keys_held = 16'h0;  // bit r*4+c = key at row r, column c
   logic        raw_en    = 1'b0;
   logic [3:0]  raw_rows  = 4'hF;

   keypad_scanner #(.SCAN_DIV(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .row_n      (row_n),
      .col_n      (col_n),
      .key_code   (key_code),
      .key_pressed(key_pressed),
      .col_idx    (col_idx)
   );

   // A row reads low when a held key connects it to the driven column.
   function automatic logic [3:0] pad_rows(input logic [15:0] keys, input logic [3:0] cols_n);
      logic [3:0] r;
      r = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if ((keys[i*4 +: 4] & ~cols_n) != 4'h0) r[i] = 1'b0;
      end
      return r;
   endfunction

   assign row_n = raw_en ? raw_rows : pad_rows(keys_held, col_n);

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / compare process ----------------
   logic       smp_reset;
   logic [3:0] smp_row;
   always @(posedge clk) begin
      smp_reset <= reset;
      smp_row   <= row_n;
   end

   initial begin : model_and_compare
      int         t;
      int         col;
      int         fr;
      bit         pressed;
      bit         ghost;
      bit         valid;
      logic [3:0] code;
      logic [3:0] rs;
      logic [3:0] low;
      logic [3:0] dly[$];
      logic [63:0] tab;
      tab   = 64'hDF0E_C987_B654_A321;  // nibble r*4+c is the code of key (r,c)
      valid = 1'b0;
      t = 0; col = 0; pressed = 1'b0; code = 4'h0;
      forever begin
         @(negedge clk);
         if (smp_reset) begin
            t = 0; col = 0; pressed = 1'b0; code = 4'h0;
            dly = '{4'hF, 4'hF};
            valid = 1'b1;
         end else if (valid) begin
            t++;
            rs = dly.pop_front();
            dly.push_back(smp_row);
            if (t % N == 0) begin
               low   = ~rs;
               ghost = 1'b0;
`ifdef GHOST_REJECT_EN
               ghost = ($countones(low) > 1);
`endif
               fr = 0;
               if (low != 4'h0) begin
                  while (!low[fr]) fr++;
               end
               if (!pressed) begin
                  if (low == 4'h0 || ghost) begin
                     col = (col + 1) % 4;
                  end else begin
                     pressed = 1'b1;
                     code    = tab[(fr*4 + col)*4 +: 4];
                  end
               end else begin
                  if (low == 4'h0) begin
                     pressed = 1'b0;
                     col     = (col + 1) % 4;
                  end else if (!ghost) begin
                     code = tab[(fr*4 + col)*4 +: 4];
                  end
               end
            end
         end
         if (valid) begin
            check("model_col_n", {4'h0, col_n}, {4'h0, 4'hF ^ (4'h1 << col)});
            check("model_col_idx", {6'h0, col_idx}, 8'(col));
            check("model_key_pressed", {7'h0, key_pressed}, {7'h0, pressed});
            check("model_key_code", {4'h0, key_code}, {4'h0, code});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Ends at the negedge just after the reset edge ("edge 0").
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] key_bit(input int r, input int c);
      return 16'h1 << (r*4 + c);
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stimulus
      logic [3:0] ring[4];
      int         nk;
      int         mode;
      ring = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      // Reset, no key: the column rotates every N cycles.
      keys_held = 16'h0;
      do_reset();
      check("rst_col_n", {4'h0, col_n}, 8'h0E);
      check("rst_col_idx", {6'h0, col_idx}, 8'h00);
      check("rst_key_pressed", {7'h0, key_pressed}, 8'h00);
      check("rst_key_code", {4'h0, key_code}, 8'h00);
      for (int j = 1; j <= 33; j++) begin
         wait_edges(1);
         check("idle_col_n", {4'h0, col_n}, {4'h0, ring[(j / N) % 4]});
         check("idle_pressed", {7'h0, key_pressed}, 8'h00);
      end

      // Key '5' held, then released.
      keys_held = key_bit(1, 1);
      do_reset();
      wait_edges(15);
      check("k5_before_sample", {7'h0, key_pressed}, 8'h00);
      wait_edges(1);
      check("k5_pressed", {7'h0, key_pressed}, 8'h01);
      check("k5_code", {4'h0, key_code}, 8'h05);
      check("k5_col_n", {4'h0, col_n}, 8'h0D);
      wait_edges(20);
      check("k5_frozen_col", {4'h0, col_n}, 8'h0D);
      check("k5_still_pressed", {7'h0, key_pressed}, 8'h01);
      keys_held = 16'h0;
      wait_edges(3);
      check("k5_release_pending", {7'h0, key_pressed}, 8'h01);
      wait_edges(1);
      check("k5_released", {7'h0, key_pressed}, 8'h00);
      check("k5_next_col", {4'h0, col_n}, 8'h0B);

      // '#' at row 3, column 2.
      keys_held = key_bit(3, 2);
      do_reset();
      wait_edges(24);
      check("hash_pressed", {7'h0, key_pressed}, 8'h01);
      check("hash_code", {4'h0, key_code}, 8'h0F);
      check("hash_col_n", {4'h0, col_n}, 8'h0B);

      // '*' at row 3, column 0.
      keys_held = key_bit(3, 0);
      do_reset();
      wait_edges(8);
      check("star_pressed", {7'h0, key_pressed}, 8'h01);
      check("star_code", {4'h0, key_code}, 8'h0E);
      check("star_col_n", {4'h0, col_n}, 8'h0E);

      // 'D' at row 3, column 3.
      keys_held = key_bit(3, 3);
      do_reset();
      wait_edges(32);
      check("d_pressed", {7'h0, key_pressed}, 8'h01);
      check("d_code", {4'h0, key_code}, 8'h0D);
      check("d_col_n", {4'h0, col_n}, 8'h07);

      // Rows 0 and 2 low in column 0.
      keys_held = key_bit(0, 0) | key_bit(2, 0);
      do_reset();
      wait_edges(8);
`ifdef GHOST_REJECT_EN
      check("ghost_rejected", {7'h0, key_pressed}, 8'h00);
      check("ghost_col_n", {4'h0, col_n}, 8'h0D);
`else
      check("multi_pressed", {7'h0, key_pressed}, 8'h01);
      check("multi_code", {4'h0, key_code}, 8'h01);
      check("multi_col_n", {4'h0, col_n}, 8'h0E);
`endif

      // Reset while holding '9'.
      keys_held = key_bit(2, 2);
      do_reset();
      wait_edges(24);
      check("k9_pressed", {7'h0, key_pressed}, 8'h01);
      check("k9_code", {4'h0, key_code}, 8'h09);
      wait_edges(5);
      do_reset();
      check("k9_rst_col_n", {4'h0, col_n}, 8'h0E);
      check("k9_rst_pressed", {7'h0, key_pressed}, 8'h00);
      check("k9_rst_code", {4'h0, key_code}, 8'h00);

      // Randomized episodes: key sets, raw row noise, and occasional resets.
      for (int ep = 0; ep < 70; ep++) begin
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            wait_edges($urandom_range(0, 7));
            do_reset();
         end else if (mode == 1) begin
            raw_en = 1'b1;
            for (int k = 0; k < $urandom_range(5, 40); k++) begin
               raw_rows = 4'($urandom_range(0, 15));
               wait_edges(1);
            end
            raw_en   = 1'b0;
            raw_rows = 4'hF;
         end else begin
            nk        = $urandom_range(0, 2);
            keys_held = 16'h0;
            for (int k = 0; k < nk; k++) begin
               keys_held = keys_held | key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            end
            wait_edges($urandom_range(4, 70));
         end
      end

      keys_held = 16'h0;
      wait_edges(40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
